hc_bist_ctrl: RTL and testbench

- Built-in self-test sequencer for the Hamming encode/decode loop.
- Pulls words from the 16-bit random-word generator and issues each one to the encoder over a valid/ready handshake.
- Drives a per-word bit-flip mask onto the channel between the encoder and the decoder.
- Checks each decoder result against the issued word and the expected error flags, and accumulates pass, fail and timeout counts for a run of N words.

---
 rtl/hc_bist_if.sv | 43 ++++
 rtl/hc_bist_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_hc_bist_ctrl.sv | 356 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hc_bist_if.sv
// Generator, encoder, channel and decoder signals seen by the BIST sequencer.
// The master side is the sequencer. The slave side is the datapath under test.
interface hc_bist_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CODE_W = 22
);
  logic [DATA_W-1:0] lfsr_data;
  logic              lfsr_en;
  logic [DATA_W-1:0] enc_data;
  logic              enc_valid;
  logic              enc_ready;
  logic [CODE_W-1:0] flip_mask;
  logic              dec_valid;
  logic [DATA_W-1:0] dec_data;
  logic              dec_err_single;
  logic              dec_err_double;

  modport master (
    input  lfsr_data,
    output lfsr_en,
    output enc_data,
    output enc_valid,
    input  enc_ready,
    output flip_mask,
    input  dec_valid,
    input  dec_data,
    input  dec_err_single,
    input  dec_err_double
  );

  modport slave (
    output lfsr_data,
    input  lfsr_en,
    input  enc_data,
    input  enc_valid,
    output enc_ready,
    input  flip_mask,
    output dec_valid,
    output dec_data,
    output dec_err_single,
    output dec_err_double
  );
endinterface

// File: rtl/hc_bist_ctrl.sv
// BIST sequencer for the Hamming encode/decode loop. It issues generator words,
// injects channel bit flips, checks decoder results and counts pass/fail/timeout.
module hc_bist_ctrl #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned CODE_W  = 22,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] num_words,
  input  logic [1:0]       err_mode,
  hc_bist_if.master        bus,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] tmo_cnt
);

  localparam int unsigned POS_W = $clog2(CODE_W);
  localparam int unsigned TMO_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
  typedef enum logic [1:0] {M_NONE = 2'd0, M_SINGLE = 2'd1, M_DOUBLE = 2'd2} mode_t;

  state_t            state;
  mode_t             mode_q;
  logic [CNT_W-1:0]  num_q;
  logic [CNT_W-1:0]  word_cnt;
  logic [POS_W-1:0]  pos;
  logic [TMO_W-1:0]  tmo_timer;
  logic [DATA_W-1:0] expected;
  logic              enc_valid_q;
  logic [CODE_W-1:0] flip_mask_q;

  mode_t             start_mode_c;
  logic              accept_c;
  logic              timeout_c;
  logic              retire_c;
  logic              word_pass_c;
  logic [POS_W-1:0]  pos_next_c;
  logic [CNT_W-1:0]  word_cnt_next_c;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + CNT_W'(1);
  endfunction

  // Single flip at pos; double flip at pos and its wrapped neighbour.
  function automatic logic [CODE_W-1:0] mask_f(input mode_t m, input logic [POS_W-1:0] p);
    logic [CODE_W-1:0] one;
    logic [POS_W-1:0]  p1;
    one = CODE_W'(1);
    p1  = (p == POS_W'(CODE_W - 1)) ? '0 : p + POS_W'(1);
    case (m)
      M_SINGLE: return one << p;
      M_DOUBLE: return (one << p) | (one << p1);
      default:  return '0;
    endcase
  endfunction

  always_comb begin
    start_mode_c    = M_NONE;
    accept_c        = 1'b0;
    timeout_c       = 1'b0;
    retire_c        = 1'b0;
    word_pass_c     = 1'b0;
    pos_next_c      = (pos == POS_W'(CODE_W - 1)) ? '0 : pos + POS_W'(1);
    word_cnt_next_c = word_cnt + CNT_W'(1);

    case (err_mode)
      2'd1:    start_mode_c = M_SINGLE;
      2'd2:    start_mode_c = M_DOUBLE;
      default: start_mode_c = M_NONE;
    endcase

    accept_c  = (state == S_ISSUE) && enc_valid_q && bus.enc_ready && !abort;
    // A result landing on the last allowed cycle wins over the timeout.
    timeout_c = (state == S_WAIT) && !bus.dec_valid && (tmo_timer == TMO_W'(TIMEOUT - 1));
    retire_c  = (state == S_WAIT) && !abort && (bus.dec_valid || timeout_c);

    case (mode_q)
      M_NONE:   word_pass_c = (bus.dec_data == expected) && !bus.dec_err_single && !bus.dec_err_double;
      M_SINGLE: word_pass_c = (bus.dec_data == expected) && bus.dec_err_single && !bus.dec_err_double;
      M_DOUBLE: word_pass_c = bus.dec_err_double;
      default:  word_pass_c = 1'b0;
    endcase
  end

  assign bus.lfsr_en   = accept_c;
  assign bus.enc_data  = (state == S_ISSUE) ? bus.lfsr_data : '0;
  assign bus.enc_valid = enc_valid_q;
  assign bus.flip_mask = flip_mask_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      mode_q      <= M_NONE;
      num_q       <= '0;
      word_cnt    <= '0;
      pos         <= '0;
      tmo_timer   <= '0;
      expected    <= '0;
      enc_valid_q <= 1'b0;
      flip_mask_q <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      aborted     <= 1'b0;
      pass_cnt    <= '0;
      fail_cnt    <= '0;
      tmo_cnt     <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            num_q    <= num_words;
            mode_q   <= start_mode_c;
            pass_cnt <= '0;
            fail_cnt <= '0;
            tmo_cnt  <= '0;
            word_cnt <= '0;
            aborted  <= 1'b0;
            busy     <= 1'b1;
            if (num_words == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state       <= S_ISSUE;
              enc_valid_q <= 1'b1;
              flip_mask_q <= mask_f(start_mode_c, pos);
            end
          end
        end
        S_ISSUE: begin
          if (abort) begin
            state       <= S_DONE;
            done        <= 1'b1;
            aborted     <= 1'b1;
            enc_valid_q <= 1'b0;
            flip_mask_q <= '0;
          end else if (accept_c) begin
            expected    <= bus.lfsr_data;
            tmo_timer   <= '0;
            enc_valid_q <= 1'b0;
            state       <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (abort) begin
            state       <= S_DONE;
            done        <= 1'b1;
            aborted     <= 1'b1;
            flip_mask_q <= '0;
          end else if (retire_c) begin
            if (timeout_c) begin
              fail_cnt <= sat_inc(fail_cnt);
              tmo_cnt  <= sat_inc(tmo_cnt);
            end else if (word_pass_c) begin
              pass_cnt <= sat_inc(pass_cnt);
            end else begin
              fail_cnt <= sat_inc(fail_cnt);
            end
            word_cnt <= word_cnt_next_c;
            pos      <= pos_next_c;
            if (word_cnt_next_c == num_q) begin
              state       <= S_DONE;
              done        <= 1'b1;
              flip_mask_q <= '0;
            end else begin
              state       <= S_ISSUE;
              enc_valid_q <= 1'b1;
              flip_mask_q <= mask_f(mode_q, pos_next_c);
            end
          end else begin
            tmo_timer <= tmo_timer + TMO_W'(1);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hc_bist_ctrl.sv
// Bench for hc_bist_ctrl: generator, channel and decoder model plus scoreboards
// for the words issued and for the results of each run.
module tb_hc_bist_ctrl;

  localparam int CODE_W  = 22;
  localparam int TIMEOUT = 64;

  typedef struct {
    int          lat;      // decode latency in cycles, 0 = never answers
    bit          drop;     // decoder loses the double-error flag
    bit          corrupt;  // decoder returns wrong data
    logic [21:0] mask;     // expected flip mask for this word
  } word_plan_t;

  typedef struct {
    int pass;
    int fail;
    int tmo;
    bit abrt;
    int issued;
  } run_exp_t;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [15:0] num_words;
  logic [1:0]  err_mode;
  logic        busy, done, aborted;
  logic [15:0] pass_cnt, fail_cnt, tmo_cnt;

  hc_bist_if #(.DATA_W(16), .CODE_W(22)) bus ();

  hc_bist_ctrl #(.DATA_W(16), .CODE_W(22), .CNT_W(16), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .num_words(num_words), .err_mode(err_mode), .bus(bus),
    .busy(busy), .done(done), .aborted(aborted),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .tmo_cnt(tmo_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hs_cnt = 0;
  int runs_done = 0;
  int stall_from = 0;
  int stall_to = 0;
  int pos_m = 0;
  bit rnd_rdy = 1'b0;
  logic [15:0] gen_word;
  int lat_a[32];
  bit drop_a[32];
  bit corrupt_a[32];

  word_plan_t plan_q[$];
  run_exp_t   run_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [21:0] exp_mask(input logic [1:0] m, input int p);
    logic [21:0] r;
    r = '0;
    if (m == 2'd1) r[p] = 1'b1;
    else if (m == 2'd2) begin
      r[p] = 1'b1;
      r[(p + 1) % CODE_W] = 1'b1;
    end
    return r;
  endfunction

  // Generator, channel/decoder model and per-word monitor.
  initial begin : env
    word_plan_t  wp;
    logic [15:0] prev_data, r_data;
    logic [21:0] prev_mask;
    bit          prev_stall, adv, pend, r_s, r_d;
    int          due;
    prev_stall = 0; adv = 0; pend = 0; due = 0;
    r_data = '0; r_s = 0; r_d = 0; prev_data = '0; prev_mask = '0;
    gen_word = 16'($urandom);
    bus.lfsr_data = gen_word;
    bus.enc_ready = 1'b1;
    bus.dec_valid = 1'b0;
    bus.dec_data = '0;
    bus.dec_err_single = 1'b0;
    bus.dec_err_double = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.enc_valid && bus.enc_ready && !abort) begin
        chk("lfsr_en_on_accept", 64'(bus.lfsr_en), 64'(1));
        hs_cnt++;
        adv = 1;
        chk("plan_available", 64'(plan_q.size() > 0), 64'(1));
        if (plan_q.size() > 0) begin
          wp = plan_q.pop_front();
          chk("enc_data", 64'(bus.enc_data), 64'(gen_word));
          chk("flip_mask", 64'(bus.flip_mask), 64'(wp.mask));
          if (wp.lat > 0) begin
            pend = 1;
            due  = cyc + 1 + wp.lat;
            case ($countones(bus.flip_mask))
              0: begin r_data = gen_word; r_s = 0; r_d = 0; end
              1: begin r_data = gen_word; r_s = 1; r_d = 0; end
              default: begin r_data = gen_word ^ 16'h5a5a; r_s = wp.drop; r_d = !wp.drop; end
            endcase
            if (wp.corrupt) r_data = r_data ^ 16'h0100;
          end
        end
        prev_stall = 0;
      end else if (bus.enc_valid) begin
        chk("lfsr_en_no_accept", 64'(bus.lfsr_en), 64'(0));
        if (prev_stall) begin
          chk("stall_data_stable", 64'(bus.enc_data), 64'(prev_data));
          chk("stall_mask_stable", 64'(bus.flip_mask), 64'(prev_mask));
        end
        prev_stall = 1;
        prev_data = bus.enc_data;
        prev_mask = bus.flip_mask;
      end else begin
        prev_stall = 0;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (adv) begin
        gen_word = 16'($urandom);
        adv = 0;
      end
      bus.lfsr_data = gen_word;
      if (pend && due == cyc + 1) begin
        bus.dec_valid = 1'b1;
        bus.dec_data = r_data;
        bus.dec_err_single = r_s;
        bus.dec_err_double = r_d;
        pend = 0;
      end else begin
        bus.dec_valid = 1'b0;
        bus.dec_data = 16'($urandom);
        bus.dec_err_single = 1'b0;
        bus.dec_err_double = 1'b0;
      end
      if (cyc >= stall_from && cyc < stall_to) bus.enc_ready = 1'b0;
      else if (rnd_rdy) bus.enc_ready = ($urandom_range(0, 3) != 0);
      else bus.enc_ready = 1'b1;
    end
  end

  // Per-run monitor: compares the result counters whenever done pulses.
  initial begin : run_mon
    run_exp_t re;
    bit       prev_done;
    int       hs_base;
    prev_done = 0;
    hs_base = 0;
    forever begin
      @(negedge clk);
      if (prev_done) begin
        chk("done_one_cycle", 64'(done), 64'(0));
        chk("idle_after_done", 64'(busy), 64'(0));
      end
      if (done === 1'b1) begin
        chk("run_expected", 64'(run_q.size() > 0), 64'(1));
        if (run_q.size() > 0) begin
          re = run_q.pop_front();
          chk("pass_cnt", 64'(pass_cnt), 64'(re.pass));
          chk("fail_cnt", 64'(fail_cnt), 64'(re.fail));
          chk("tmo_cnt", 64'(tmo_cnt), 64'(re.tmo));
          chk("aborted", 64'(aborted), 64'(re.abrt));
          chk("done_mask_zero", 64'(bus.flip_mask), 64'(0));
          chk("words_issued", 64'(hs_cnt - hs_base), 64'(re.issued));
        end
        hs_base = hs_cnt;
        runs_done++;
      end
      prev_done = (done === 1'b1);
    end
  end

  task automatic set_plan(input int n, input int lat);
    for (int i = 0; i < 32; i++) begin
      lat_a[i] = (i < n) ? lat : 0;
      drop_a[i] = 0;
      corrupt_a[i] = 0;
    end
  endtask

  // Pushes the expected words and run result, then drives one run to done.
  task automatic run_words(input int n, input logic [1:0] mode, input int abort_word,
                           input bit poke_start, input bit stall, input int max_done_wait);
    run_exp_t   re;
    word_plan_t wp;
    logic [1:0] eff;
    int p, issued, base, rd, t;
    eff = (mode == 2'd3) ? 2'd0 : mode;
    p = pos_m;
    issued = (abort_word >= 0) ? abort_word + 1 : n;
    re.pass = 0; re.fail = 0; re.tmo = 0;
    re.abrt = (abort_word >= 0);
    re.issued = issued;
    for (int i = 0; i < issued; i++) begin
      wp.lat = lat_a[i];
      wp.drop = drop_a[i];
      wp.corrupt = corrupt_a[i];
      wp.mask = exp_mask(eff, p);
      plan_q.push_back(wp);
      if (i != abort_word) begin
        if (lat_a[i] == 0 || lat_a[i] > TIMEOUT) begin
          re.fail++;
          re.tmo++;
        end else if ((eff == 2'd2) ? !drop_a[i] : !corrupt_a[i]) re.pass++;
        else re.fail++;
        p = (p + 1) % CODE_W;
      end
    end
    run_q.push_back(re);
    pos_m = p;
    base = hs_cnt;
    rd = runs_done;
    @(posedge clk);
    #2;
    if (stall) begin
      stall_from = cyc + 1;
      stall_to = cyc + 7;
    end
    start = 1'b1;
    num_words = 16'(n);
    err_mode = mode;
    @(posedge clk);
    #2;
    start = 1'b0;
    num_words = 16'($urandom);
    err_mode = 2'($urandom);
    if (poke_start) begin
      repeat (4) @(posedge clk);
      #2;
      start = 1'b1;
      num_words = 16'd3;
      @(posedge clk);
      #2;
      start = 1'b0;
    end
    if (abort_word >= 0) begin
      t = 0;
      while (hs_cnt < base + issued && t < 1000) begin
        @(posedge clk);
        t++;
      end
      chk("abort_word_reached", 64'(hs_cnt >= base + issued), 64'(1));
      repeat (3) @(posedge clk);
      #2;
      abort = 1'b1;
      @(posedge clk);
      #2;
      abort = 1'b0;
    end
    t = 0;
    while (runs_done == rd && t < 4000) begin
      @(posedge clk);
      t++;
    end
    chk("run_completes", 64'(runs_done != rd), 64'(1));
    if (max_done_wait > 0) chk("done_latency_ok", 64'(t <= max_done_wait), 64'(1));
    repeat (2) @(posedge clk);
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog act=no finish exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    rst = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    num_words = '0;
    err_mode = '0;

    // Reset held with toggling inputs.
    repeat (3) begin
      @(posedge clk);
      #2;
      start = 1'($urandom);
      abort = 1'($urandom);
      num_words = 16'($urandom);
      err_mode = 2'($urandom);
      @(negedge clk);
      chk("reset_status", 64'({busy, done, aborted, bus.enc_valid, bus.lfsr_en}), 64'(0));
      chk("reset_counters", 64'({pass_cnt, fail_cnt, tmo_cnt}), 64'(0));
      chk("reset_bus", 64'({bus.flip_mask, bus.enc_data}), 64'(0));
    end
    @(posedge clk);
    #2;
    start = 1'b0;
    abort = 1'b0;
    rst = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("idle_no_start_busy", 64'(busy), 64'(0));
    chk("idle_no_start_words", 64'(hs_cnt), 64'(0));

    // Single flips across the pos wrap.
    set_plan(25, 2);
    run_words(25, 2'd1, -1, 0, 0, 0);

    // Clean run with a start poked mid-run.
    set_plan(8, 3);
    run_words(8, 2'd0, -1, 1, 0, 0);

    // Double flips with the flag lost on the last word.
    set_plan(4, 3);
    drop_a[3] = 1;
    run_words(4, 2'd2, -1, 0, 0, 0);

    // Backpressure, a silent decoder, then a result on the last wait cycle.
    set_plan(3, 3);
    lat_a[1] = 0;
    lat_a[2] = TIMEOUT;
    run_words(3, 2'd0, -1, 0, 1, 0);

    // Abort while waiting on the second word.
    set_plan(10, 2);
    lat_a[1] = 0;
    run_words(10, 2'd1, 1, 0, 0, 0);

    // Empty run.
    set_plan(0, 0);
    run_words(0, 2'd1, -1, 0, 0, 2);

    // Randomized runs with random ready.
    rnd_rdy = 1'b1;
    for (int r = 0; r < 8; r++) begin
      int n;
      n = $urandom_range(1, 6);
      set_plan(0, 0);
      for (int i = 0; i < n; i++) begin
        lat_a[i] = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 12);
        drop_a[i] = ($urandom_range(0, 3) == 0);
        corrupt_a[i] = ($urandom_range(0, 3) == 0);
      end
      run_words(n, 2'($urandom_range(0, 3)), -1, 0, 0, 0);
    end

    chk("plan_drained", 64'(plan_q.size()), 64'(0));
    chk("runs_drained", 64'(run_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
